da_dct_engine: RTL and testbench

- Parametrised bit-serial distributed-arithmetic (DA) engine for the DCT stage of the EEG compression path.
- Replaces the fixed per-row coefficient ROMs with runtime-loadable per-lane LUTs.
- Accepts a group of N_TAPS signed samples and computes N_LANES inner products in parallel, one input bit-plane per cycle.
- Sits between the sample-framing buffer and the RLE encoder; valid/ready on both sides.

---
 rtl/da_dct_pkg.sv | 28 ++
 rtl/da_lane.sv | 73 +++++++
 rtl/da_dct_engine.sv | 118 +++++++++++
 tb/tb_da_dct_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_dct_pkg.sv
// Shared state type, DCT cosine constants (Q2.14) and width helpers for the DA DCT engine.
// The DA_ROUND_EN build macro selects round-half-up output in da_lane. The default build uses floor.
package da_dct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // cos(k*pi/16) in Q2.14
  localparam logic [15:0] C1 = 16'h3EC5;
  localparam logic [15:0] C2 = 16'h3B21;
  localparam logic [15:0] C3 = 16'h3537;
  localparam logic [15:0] C4 = 16'h2D41;
  localparam logic [15:0] C5 = 16'h238E;
  localparam logic [15:0] C6 = 16'h187D;
  localparam logic [15:0] C7 = 16'h0C7C;

  function automatic int acc_width(input int coef_w, input int in_w);
    return coef_w + in_w + 1;
  endfunction

  function automatic int out_width(input int acc_w, input int out_shift);
    return acc_w - out_shift;
  endfunction

endpackage

// File: rtl/da_lane.sv
// One DA lane: runtime-loadable 2^N_TAPS coefficient LUT plus its bit-serial accumulator.
// Build macro DA_ROUND_EN adds half an output LSB before the final shift (round half up).
module da_lane
  import da_dct_pkg::*;
#(
  parameter int N_TAPS    = 4,
  parameter int IN_W      = 12,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 14,
  parameter int CNT_W     = $clog2(IN_W + 1),
  localparam int ACC_W    = acc_width(COEF_W, IN_W),
  localparam int OUT_W    = out_width(ACC_W, OUT_SHIFT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [N_TAPS-1:0] cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              clear,
  input  logic              step,
  input  logic              sign_plane,
  input  logic [CNT_W-1:0]  bit_idx,
  input  logic [N_TAPS-1:0] addr,
  input  logic              capture,
  output logic [OUT_W-1:0]  result
);

  logic [COEF_W-1:0]       lut [2**N_TAPS];
  logic [COEF_W-1:0]       coef;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_out;

  assign coef = lut[addr];
  assign term = $signed({{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef}) <<< bit_idx;

  // NOTE: the LUT is a small flop array, so it takes the async reset like any other state; a RAM-mapped LUT could not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**N_TAPS; i++) lut[i] <= '0;
    end else if (cfg_we) begin
      lut[cfg_addr] <= cfg_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sign_plane ? acc - term : acc + term;
    end
  end

`ifdef DA_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (OUT_SHIFT - 1);
  assign acc_out = acc + HALF;
`else
  assign acc_out = acc;
`endif

  // Captured once after the sign plane, so the result stays stable through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (capture) begin
      result <= OUT_W'(acc_out >>> OUT_SHIFT);
    end
  end

endmodule

// File: rtl/da_dct_engine.sv
// Bit-serial distributed-arithmetic DCT engine: N_LANES inner products over N_TAPS signed samples.
// Build macro DA_ROUND_EN selects round-half-up output; the default build floors.
module da_dct_engine
  import da_dct_pkg::*;
#(
  parameter int N_TAPS    = 4,
  parameter int N_LANES   = 2,
  parameter int IN_W      = 12,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 14,
  localparam int ACC_W    = acc_width(COEF_W, IN_W),
  localparam int OUT_W    = out_width(ACC_W, OUT_SHIFT),
  localparam int LANE_W   = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_TAPS*IN_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANES*OUT_W-1:0] out_data,
  input  logic                     cfg_we,
  input  logic [LANE_W-1:0]        cfg_lane,
  input  logic [N_TAPS-1:0]        cfg_addr,
  input  logic [COEF_W-1:0]        cfg_wdata,
  output logic                     busy
);

  localparam int CNT_W = $clog2(IN_W + 1);

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       bit_idx;
  logic [N_TAPS*IN_W-1:0] x_reg;
  logic [N_TAPS-1:0]      addr;
  logic                   accept;
  logic                   step;
  logic                   capture;
  logic                   sign_plane;
  logic                   cfg_ok;

  assign accept     = in_valid && (state == IDLE);
  assign step       = (state == SHIFT) && (bit_idx != CNT_W'(IN_W));
  assign capture    = (state == SHIFT) && (bit_idx == CNT_W'(IN_W));
  assign sign_plane = (bit_idx == CNT_W'(IN_W - 1));
  // A write landing on the accept edge is dropped so the accepted group sees the old LUT.
  assign cfg_ok     = cfg_we && (state == IDLE) && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_n unassigned and no latch is inferred.
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid)  state_n = SHIFT;
      SHIFT:   if (capture)   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Each sample slice shifts right once per plane, so its LSB is always the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      x_reg   <= in_data;
      bit_idx <= '0;
    end else if (step) begin
      for (int j = 0; j < N_TAPS; j++) x_reg[j*IN_W +: IN_W] <= x_reg[j*IN_W +: IN_W] >> 1;
      bit_idx <= bit_idx + CNT_W'(1);
    end
  end

  // Slice j holds x_{N_TAPS-1-j}, so x0 lands on the address MSB.
  always_comb begin
    addr = '0;
    for (int j = 0; j < N_TAPS; j++) addr[j] = x_reg[j*IN_W];
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic lane_we;
    assign lane_we = cfg_ok && (cfg_lane == LANE_W'(i));

    da_lane #(
      .N_TAPS    (N_TAPS),
      .IN_W      (IN_W),
      .COEF_W    (COEF_W),
      .OUT_SHIFT (OUT_SHIFT),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (lane_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .clear      (accept),
      .step       (step),
      .sign_plane (sign_plane),
      .bit_idx    (bit_idx),
      .addr       (addr),
      .capture    (capture),
      .result     (out_data[(N_LANES-1-i)*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_da_dct_engine.sv
// Self-checking bench for da_dct_engine: directed table, handshake/config/reset sequences, random inner products.
// Honours DA_ROUND_EN when the design is built with it.
module tb_da_dct_engine;
  import da_dct_pkg::*;

  localparam int N_TAPS    = 4;
  localparam int N_LANES   = 2;
  localparam int IN_W      = 12;
  localparam int COEF_W    = 16;
  localparam int OUT_SHIFT = 14;
  localparam int ACC_W     = acc_width(COEF_W, IN_W);
  localparam int OUT_W     = out_width(ACC_W, OUT_SHIFT);
  localparam int LANE_W    = $clog2(N_LANES);
  localparam int LATENCY   = IN_W + 1;
`ifdef DA_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef int samples_t [N_TAPS];
  typedef struct {
    logic [N_TAPS-1:0] addr;
    logic [COEF_W-1:0] val;
    samples_t          x;
    int                exp_floor;
    int                exp_round;
  } vec_t;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_TAPS*IN_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_LANES*OUT_W-1:0] out_data;
  logic                     cfg_we;
  logic [LANE_W-1:0]        cfg_lane;
  logic [N_TAPS-1:0]        cfg_addr;
  logic [COEF_W-1:0]        cfg_wdata;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  da_dct_engine #(
    .N_TAPS(N_TAPS), .N_LANES(N_LANES), .IN_W(IN_W), .COEF_W(COEF_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane_out(input logic [N_LANES*OUT_W-1:0] d, input int lane);
    logic signed [OUT_W-1:0] v;
    v = d[(N_LANES-1-lane)*OUT_W +: OUT_W];
    return int'(v);
  endfunction

  function automatic logic [N_TAPS*IN_W-1:0] pack(input samples_t x);
    logic [N_TAPS*IN_W-1:0] d;
    d = '0;
    for (int k = 0; k < N_TAPS; k++) d[(N_TAPS-1-k)*IN_W +: IN_W] = IN_W'(x[k]);
    return d;
  endfunction

  // Reference: exact inner product, then floor or round-half-up division by 2^OUT_SHIFT.
  function automatic int model_out(input longint acc);
    longint a;
    a = ROUND ? acc + (64'sd1 <<< (OUT_SHIFT - 1)) : acc;
    return int'(a >>> OUT_SHIFT);
  endfunction

  function automatic vec_t mk_vec(input logic [N_TAPS-1:0] a, input logic [COEF_W-1:0] v,
                                  input int x0, input int x1, input int x2, input int x3,
                                  input int ef, input int er);
    vec_t r;
    r.addr = a; r.val = v;
    r.x[0] = x0; r.x[1] = x1; r.x[2] = x2; r.x[3] = x3;
    r.exp_floor = ef; r.exp_round = er;
    return r;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic cfg_write(input int lane, input int a, input logic [COEF_W-1:0] v);
    cfg_we    = 1'b1;
    cfg_lane  = LANE_W'(lane);
    cfg_addr  = N_TAPS'(a);
    cfg_wdata = v;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Offers a group, waits for the accept edge, then measures edges until out_valid.
  task automatic run_group(input samples_t x, input int hold,
                           output logic [N_LANES*OUT_W-1:0] res, output int lat);
    int w;
    w = 0;
    in_data  = pack(x);
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    res = out_data;
    repeat (hold) tick();
    retire();
  endtask

  initial begin
    vec_t                     vecs [4];
    logic [N_LANES*OUT_W-1:0] res;
    logic [N_LANES*OUT_W-1:0] held;
    logic [COEF_W-1:0]        pool [7];
    samples_t                 x;
    int                       lat;
    int                       seen;
    int                       coef [N_LANES][N_TAPS];
    longint                   acc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_lane = '0; cfg_addr = '0; cfg_wdata = '0;
    tick();
    tick();
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Directed table: single LUT entry in lane 0, lane 1 left at zero.
    vecs[0] = mk_vec(4'h1, C6,       0,    0, 0, 300,  114,   115);
    vecs[1] = mk_vec(4'h1, C6,       0,    0, 0,  -1,   -1,     0);
    vecs[2] = mk_vec(4'h5, 16'h539E, 0, 2047, 0, 2047, 2674,  2674);
    vecs[3] = mk_vec(4'h8, C2,   -2048,    0, 0,    0, -1893, -1892);
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      cfg_write(0, int'(vecs[i].addr), vecs[i].val);
      run_group(vecs[i].x, 0, res, lat);
      check($sformatf("vec%0d lane0", i), lane_out(res, 0), ROUND ? vecs[i].exp_round : vecs[i].exp_floor);
      check($sformatf("vec%0d lane1", i), lane_out(res, 1), 0);
      check($sformatf("vec%0d latency", i), lat, LATENCY);
    end

    // Backpressure in DONE: output held, no second accept until the cycle after retirement.
    apply_reset();
    cfg_write(0, 1, C6);
    cfg_write(1, 1, 16'hE783);
    x = '{0, 0, 0, 300};
    in_data = pack(x); in_valid = 1'b1;
    tick();
    x = '{0, 0, 0, -1};
    in_data = pack(x);
    wait_out(lat);
    check("hold latency", lat, LATENCY);
    check("hold lane0", lane_out(out_data, 0), model_out(6269 * 300));
    check("hold lane1", lane_out(out_data, 1), model_out(-6269 * 300));
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold stable c%0d", c), out_data, held);
      check($sformatf("hold in_ready c%0d", c), in_ready, 0);
      check($sformatf("hold out_valid c%0d", c), out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("retire out_valid", out_valid, 0);
    check("retire busy", busy, 0);
    check("retire in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("second accept busy", busy, 1);
    wait_out(lat);
    check("second latency", lat, LATENCY);
    check("second lane0", lane_out(out_data, 0), model_out(-6269));
    check("second lane1", lane_out(out_data, 1), model_out(6269));
    retire();

    // Config write while busy is dropped.
    apply_reset();
    cfg_write(0, 1, C6);
    x = '{0, 0, 0, 300};
    in_data = pack(x); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("busy during write", busy, 1);
    cfg_write(0, 1, 16'h7FFF);
    wait_out(lat);
    check("busy write lane0", lane_out(out_data, 0), model_out(6269 * 300));
    retire();
    run_group(x, 1, res, lat);
    check("after busy write lane0", lane_out(res, 0), model_out(6269 * 300));

    // Write coinciding with the accept: the group sees the old value.
    apply_reset();
    cfg_write(0, 1, C6);
    in_data = pack(x); in_valid = 1'b1;
    cfg_we = 1'b1; cfg_lane = '0; cfg_addr = 4'h1; cfg_wdata = 16'h2000;
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    wait_out(lat);
    check("accept write lane0", lane_out(out_data, 0), model_out(6269 * 300));
    retire();

    // Reset at bit plane 5 aborts the group and clears the LUT.
    apply_reset();
    cfg_write(0, 1, C6);
    in_data = pack(x); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort out_data", out_data, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort no output", seen, 0);
    run_group(x, 0, res, lat);
    check("post-abort lane0", lane_out(res, 0), 0);
    check("post-abort latency", lat, LATENCY);

    // Random linear LUTs: LUT[a] = sum of coefficients whose address bit is set.
    pool = '{C1, C2, C3, C4, C5, C6, C7};
    apply_reset();
    for (int l = 0; l < N_LANES; l++) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if ($urandom_range(0, 1) == 1) coef[l][k] = int'($signed(pool[$urandom_range(0, 6)])) / 2;
        else                           coef[l][k] = int'($urandom_range(0, 16000)) - 8000;
        if ($urandom_range(0, 1) == 1) coef[l][k] = -coef[l][k];
      end
      for (int a = 0; a < 2**N_TAPS; a++) begin
        int v;
        v = 0;
        for (int k = 0; k < N_TAPS; k++) if (a[N_TAPS-1-k]) v += coef[l][k];
        cfg_write(l, a, COEF_W'(v));
      end
    end
    for (int g = 0; g < 24; g++) begin
      for (int k = 0; k < N_TAPS; k++) begin
        case (g)
          0:       x[k] = -2048;
          1:       x[k] = 2047;
          2:       x[k] = (k % 2 == 0) ? -2048 : 2047;
          default: x[k] = int'($urandom_range(0, 4095)) - 2048;
        endcase
      end
      run_group(x, int'($urandom_range(0, 3)), res, lat);
      check($sformatf("rand%0d latency", g), lat, LATENCY);
      for (int l = 0; l < N_LANES; l++) begin
        acc = 0;
        for (int k = 0; k < N_TAPS; k++) acc += longint'(coef[l][k]) * longint'(x[k]);
        check($sformatf("rand%0d lane%0d", g, l), lane_out(res, l), model_out(acc));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
